// File: rtl/rca_pipe_adder_unit_if.sv
// Issue / writeback bus of the pipelined ripple-carry adder unit.
// The unit is the slave; the issuing core and the writeback consumer form the master.
interface rca_pipe_adder_unit_if #(
    parameter int WIDTH = 32,
    parameter int ID_W  = 3
);
    // Issue side
    logic             issue_new;
    logic [ID_W-1:0]  issue_id;
    logic             issue_sub;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             issue_ready;

    // Writeback side
    logic             wb_done;
    logic [ID_W-1:0]  wb_id;
    logic [WIDTH-1:0] wb_rd;
    logic             wb_carry;
    logic             wb_overflow;
    logic             wb_ack;

    modport master (
        output issue_new, issue_id, issue_sub, rs1, rs2, wb_ack,
        input  issue_ready, wb_done, wb_id, wb_rd, wb_carry, wb_overflow
    );

    modport slave (
        input  issue_new, issue_id, issue_sub, rs1, rs2, wb_ack,
        output issue_ready, wb_done, wb_id, wb_rd, wb_carry, wb_overflow
    );
endinterface

// File: rtl/rca_pipe_adder_unit.sv
// Pipelined ripple-carry add/sub unit with an in-order writeback FIFO.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits; slice k is
// added at the k-th edge after issue, the last slice feeding the FIFO directly.
// A credit counter (in-flight + buffered) throttles issue so the pipeline never
// stalls and the FIFO never overflows.
// Optional feature: define RCA_ADDER_OVERFLOW_EN to store and report signed
// overflow per result; otherwise wb_overflow is tied low.
module rca_pipe_adder_unit #(
    parameter int WIDTH      = 32,
    parameter int STAGES     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    rca_pipe_adder_unit_if.slave bus
);

    localparam int SW = WIDTH / STAGES;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

    // Everything one pipeline stage hands to the next.
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] a;    // rs1, upper slices still pending
        logic [WIDTH-1:0] b;    // rs2 or ~rs2, upper slices still pending
        logic [WIDTH-1:0] sum;  // finished lower slices
        logic             cy;   // carry into the next slice
    } stage_t;

    logic          w_ready;
    logic          w_accept;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    stage_t        w_res;

    logic [PW:0]   r_wptr;
    logic [PW:0]   r_rptr;
    logic [CW-1:0] r_credit;
    logic [PW-1:0] w_widx;
    logic [PW-1:0] w_ridx;

    assign w_ready  = (r_credit < CREDIT_MAX);
    assign w_accept = bus.issue_new & w_ready;

    // ------------------------------------------------------------------
    // Carry-chain pipeline
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t        w_in;
        logic          w_vin;
        logic [SW:0]   w_slice;
        stage_t        w_out;

        if (k == 0) begin : g_src
            // Subtraction is rs1 + ~rs2 + 1, so the inverted operand and the
            // carry-in are both formed here at issue.
            assign w_in.id  = bus.issue_id;
            assign w_in.a   = bus.rs1;
            assign w_in.b   = bus.issue_sub ? ~bus.rs2 : bus.rs2;
            assign w_in.sum = '0;
            assign w_in.cy  = bus.issue_sub;
            assign w_vin    = w_accept;
        end else begin : g_src
            assign w_in  = g_stage[k-1].g_reg.r_q;
            assign w_vin = g_stage[k-1].g_reg.r_vld;
        end

        assign w_slice = {1'b0, w_in.a[k*SW +: SW]}
                       + {1'b0, w_in.b[k*SW +: SW]}
                       + {{SW{1'b0}}, w_in.cy};

        // Insert this slice's sum and carry into the travelling record.
        always_comb begin
            // NOTE: the whole record gets a default first so no field can
            // fall through unassigned and infer a latch.
            w_out                 = w_in;
            w_out.sum[k*SW +: SW] = w_slice[SW-1:0];
            w_out.cy              = w_slice[SW];
        end

        if (k < STAGES - 1) begin : g_reg
            stage_t r_q;
            logic   r_vld;

            // Stage valid bit, cleared immediately by reset.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // flop samples the pre-edge value of its inputs.
                if (rst) r_vld <= 1'b0;
                else     r_vld <= w_vin;
            end

            // Stage payload; only meaningful while r_vld is set.
            always_ff @(posedge clk) begin
                if (w_vin) r_q <= w_out;
            end
        end
    end

    assign w_push = g_stage[STAGES-1].w_vin;
    assign w_res  = g_stage[STAGES-1].w_out;

    // ------------------------------------------------------------------
    // Writeback FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_fifo_rd [FIFO_DEPTH];
    logic [ID_W-1:0]  r_fifo_id [FIFO_DEPTH];
    logic             r_fifo_cy [FIFO_DEPTH];

    assign w_empty = (r_wptr == r_rptr);
    assign w_pop   = bus.wb_ack & ~w_empty;
    assign w_widx  = r_wptr[PW-1:0];
    assign w_ridx  = r_rptr[PW-1:0];

    // Result storage written at the end of the last stage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers decide what is
        // valid and the outputs are masked while the FIFO is empty.
        if (w_push) begin
            r_fifo_rd[w_widx] <= w_res.sum;
            r_fifo_id[w_widx] <= w_res.id;
            r_fifo_cy[w_widx] <= w_res.cy;
        end
    end

`ifdef RCA_ADDER_OVERFLOW_EN
    logic                  w_ovf;
    logic [FIFO_DEPTH-1:0] r_fifo_ovf;

    // Signed overflow of the final slice: operands agree in sign but the
    // sum does not (same as carry-into-MSB XOR carry-out).
    assign w_ovf = (g_stage[STAGES-1].w_in.a[WIDTH-1] == g_stage[STAGES-1].w_in.b[WIDTH-1])
                 & (w_res.sum[WIDTH-1] != g_stage[STAGES-1].w_in.a[WIDTH-1]);

    // Per-entry overflow flag, written alongside the result.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_ovf[w_widx] <= w_ovf;
    end

    assign bus.wb_overflow = ~w_empty & r_fifo_ovf[w_ridx];
`else
    assign bus.wb_overflow = 1'b0;
`endif

    // Read/write pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
        end
    end

    // Credits = results in flight plus results buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= '0;
        end else if (w_accept && !w_pop) begin
            r_credit <= r_credit + CW'(1);
        end else if (!w_accept && w_pop) begin
            r_credit <= r_credit - CW'(1);
        end
    end

    assign bus.issue_ready = w_ready;
    assign bus.wb_done     = ~w_empty;
    assign bus.wb_id       = w_empty ? '0 : r_fifo_id[w_ridx];
    assign bus.wb_rd       = w_empty ? '0 : r_fifo_rd[w_ridx];
    assign bus.wb_carry    = ~w_empty & r_fifo_cy[w_ridx];

endmodule
